// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first, centre-sampled, with a 2-flop input synchroniser.
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 433
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       uart_rxd,
  output logic [7:0] data,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int unsigned CW   = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned HALF = (CLKS_PER_BIT - 1) / 2;

  localparam logic [CW-1:0] HALF_CNT = CW'(HALF);
  localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  state_t        state, state_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [2:0]    bit_idx, bit_idx_d;
  logic [7:0]    shift_reg, shift_d;
  logic [7:0]    data_d;
  logic          data_valid_d;
  logic          frame_err_d;
  logic          rx_meta, rx_s;

  // Two-flop synchroniser; flops reset to the idle (high) line level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= uart_rxd;
      rx_s    <= rx_meta;
    end
  end

  // State, timing counter, shift register and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= '0;
      shift_reg  <= '0;
      data       <= '0;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      bit_idx    <= bit_idx_d;
      shift_reg  <= shift_d;
      data       <= data_d;
      data_valid <= data_valid_d;
      frame_err  <= frame_err_d;
    end
  end

  // Next-state logic: counter restarts on every state change and every data bit.
  always_comb begin
    state_d      = state;
    cnt_d        = cnt + CW'(1);
    bit_idx_d    = bit_idx;
    shift_d      = shift_reg;
    data_d       = data;
    data_valid_d = 1'b0;
    frame_err_d  = 1'b0;

    unique case (state)
      IDLE: begin
        cnt_d     = '0;
        bit_idx_d = '0;
        if (!rx_s) begin
          state_d = START;
        end
      end

      START: begin
        // Centre of the start bit: a high line here was only a glitch.
        if (cnt == HALF_CNT) begin
          cnt_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end
      end

      DATA: begin
        if (cnt == LAST_CNT) begin
          cnt_d            = '0;
          shift_d[bit_idx] = rx_s;
          if (bit_idx == 3'd7) begin
            state_d = STOP;
          end else begin
            bit_idx_d = bit_idx + 3'd1;
          end
        end
      end

      STOP: begin
        // Leaving at the stop-bit centre lets a zero-gap start bit be caught.
        if (cnt == LAST_CNT) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d       = shift_reg;
            data_valid_d = 1'b1;
            state_d      = IDLE;
          end else begin
            frame_err_d = 1'b1;
            state_d     = WAIT_HIGH;
          end
        end
      end

      WAIT_HIGH: begin
        // A held-low (break) line must not be read as a stream of start bits.
        cnt_d = '0;
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // Busy decoded directly from state.
  assign busy = (state != IDLE);

endmodule
